// File: rtl/fetch_dreg.sv
// Fetch-stage decode feeding the F (predicted PC) and D pipeline registers; IMEM_BOUNDS_EN enables fetch-address range checks.
// Latency: one cycle from nPC/imem_bytes to the D outputs; imem_addr is a combinational copy of nPC.
// Backpressure: F_stall holds FpredPC, D_stall holds D (D_bubble wins); a fetched HLT/INS/ADR halts fetch until reset.
module fetch_dreg #(
    parameter int IMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] nPC,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_bytes,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    output logic [63:0] FpredPC,
    output logic        f_halted,
    output logic [3:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);
    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;
    localparam logic [3:0] IC_HALT  = 4'h0;
    localparam logic [3:0] IC_NOP   = 4'h1;
    localparam logic [3:0] IC_JXX   = 4'h7;
    localparam logic [3:0] IC_CALL  = 4'h8;
    localparam logic [3:0] IC_MAX   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    logic [3:0]  raw_icode, raw_ifun, ilen;
    logic        need_regids, need_valc, adr, f_stop;
    logic [63:0] raw_valc, raw_valp;
    logic [3:0]  f_stat, f_icode, f_ifun, f_ra, f_rb;
    logic [63:0] f_valc, f_valp, f_pred;

    assign imem_addr = nPC;
    assign raw_icode = imem_bytes[7:4];
    assign raw_ifun  = imem_bytes[3:0];

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (raw_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            4'h7, 4'h8: need_valc = 1'b1;
            default: ;
        endcase
    end

    assign ilen     = 4'd1 + {3'd0, need_regids} + {need_valc, 3'b000};
    assign raw_valc = need_valc ? (need_regids ? imem_bytes[79:16] : imem_bytes[71:8]) : 64'd0;
    assign raw_valp = nPC + {60'd0, ilen};

`ifdef IMEM_BOUNDS_EN
    localparam logic [64:0] IMEM_LIM = 65'(IMEM_SIZE);
    // 65-bit sum so a PC near 2^64 cannot wrap back into the legal range.
    assign adr = ({1'b0, nPC} + {61'd0, ilen}) > IMEM_LIM;
`else
    logic unused_imem_size;
    assign unused_imem_size = (IMEM_SIZE != 0);
    assign adr = 1'b0;
`endif

    always_comb begin
        f_stat  = STAT_AOK;
        f_icode = raw_icode;
        f_ifun  = raw_ifun;
        f_ra    = need_regids ? imem_bytes[15:12] : REG_NONE;
        f_rb    = need_regids ? imem_bytes[11:8]  : REG_NONE;
        f_valc  = raw_valc;
        f_valp  = raw_valp;
        if (adr || raw_icode > IC_MAX) begin
            f_stat  = adr ? STAT_ADR : STAT_INS;
            f_icode = IC_NOP;
            f_ifun  = 4'd0;
            f_ra    = REG_NONE;
            f_rb    = REG_NONE;
            f_valc  = 64'd0;
            f_valp  = adr ? nPC : nPC + 64'd1;
        end else if (raw_icode == IC_HALT) begin
            f_stat = STAT_HLT;
        end
    end

    assign f_pred = (f_icode == IC_JXX || f_icode == IC_CALL) ? f_valc : f_valp;
    assign f_stop = (f_stat != STAT_AOK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FpredPC  <= 64'd0;
            f_halted <= 1'b0;
        end else if (!F_stall && !f_halted) begin
            FpredPC <= f_pred;
            if (f_stop) f_halted <= 1'b1;
        end
    end

    // Once halted nothing fetched may enter D; it drains to bubbles unless D is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_stat  <= STAT_AOK;
            D_icode <= IC_NOP;
            D_ifun  <= 4'd0;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= 64'd0;
            D_valP  <= 64'd0;
        end else if (D_bubble || (!D_stall && f_halted)) begin
            D_stat  <= STAT_AOK;
            D_icode <= IC_NOP;
            D_ifun  <= 4'd0;
            D_rA    <= REG_NONE;
            D_rB    <= REG_NONE;
            D_valC  <= 64'd0;
            D_valP  <= 64'd0;
        end else if (!D_stall) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_ra;
            D_rB    <= f_rb;
            D_valC  <= f_valc;
            D_valP  <= f_valp;
        end
    end
endmodule

// File: tb/tb_fetch_dreg.sv
// Scoreboard bench for fetch_dreg: expected D/F state is queued when stimulus is driven and compared after the edge.
module tb_fetch_dreg;
    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] fpred;
        logic        halted;
    } dout_t;

    localparam logic [79:0] IRMOVQ = 80'h0000_0000_0000_000A_F330;
    localparam logic [79:0] JMP100 = 80'h0000_0000_0000_0001_0070;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] nPC = 64'd0;
    logic [63:0] imem_addr;
    logic [79:0] imem_bytes = 80'd0;
    logic        F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
    logic [63:0] FpredPC, D_valC, D_valP;
    logic        f_halted;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    dout_t       obs, e;
    dout_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;

    fetch_dreg dut (
        .clk(clk), .rst_n(rst_n), .nPC(nPC), .imem_addr(imem_addr), .imem_bytes(imem_bytes),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .FpredPC(FpredPC),
        .f_halted(f_halted), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
    );

    always #5 clk = ~clk;
    assign obs = {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, FpredPC, f_halted};

    function automatic dout_t mk(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                                 input logic [63:0] vp, input logic [63:0] fp, input logic h);
        return {st, ic, fn, ra, rb, vc, vp, fp, h};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) cycle();
        exp_q.push_back(mk(4'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset got=%h exp=%h", obs, e); end
        rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        do_reset();
        nPC = 64'h10; imem_bytes = IRMOVQ;
        #1; checks++;
        if (imem_addr !== 64'h10) begin errors++; $display("FAIL imem_addr got=%h exp=%h", imem_addr, 64'h10); end
        exp_q.push_back(mk(4'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'h1A, 64'h1A, 1'b0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL irmovq got=%h exp=%h", obs, e); end
    endtask

    task automatic test_jmp();
        do_reset();
        nPC = 64'h20; imem_bytes = JMP100;
        exp_q.push_back(mk(4'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 64'h100, 1'b0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL jmp got=%h exp=%h", obs, e); end
    endtask

    task automatic test_stall();
        dout_t held;
        do_reset();
        nPC = 64'h20; imem_bytes = JMP100;
        held = mk(4'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 64'h100, 1'b0);
        exp_q.push_back(held);
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_load got=%h exp=%h", obs, e); end
        F_stall = 1'b1; D_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nPC = 64'h80 + 64'(i * 16);
            imem_bytes = (i == 0) ? IRMOVQ : 80'd0;
            exp_q.push_back(held);
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, e); end
        end
        D_bubble = 1'b1;
        exp_q.push_back(mk(4'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'h100, 1'b0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL bubble_over_stall got=%h exp=%h", obs, e); end
    endtask

    task automatic test_ins_halt();
        do_reset();
        nPC = 64'h40; imem_bytes = 80'h0000_0000_0000_0000_11C0;
        exp_q.push_back(mk(4'd4, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 64'h41, 1'b1));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL ins got=%h exp=%h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            nPC = 64'h60 + 64'(i); imem_bytes = IRMOVQ;
            D_stall = (i == 2);
            exp_q.push_back(mk(4'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'h41, 1'b1));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL ins_drain%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_hlt_reset();
        do_reset();
        nPC = 64'h50; imem_bytes = 80'd0;
        exp_q.push_back(mk(4'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h51, 64'h51, 1'b1));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL hlt got=%h exp=%h", obs, e); end
        F_stall = 1'b1; D_stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(4'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
        rst_n = 1'b1; F_stall = 1'b0; D_stall = 1'b0;
        nPC = 64'h10; imem_bytes = IRMOVQ;
        exp_q.push_back(mk(4'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'h1A, 64'h1A, 1'b0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL after_reset got=%h exp=%h", obs, e); end
    endtask

    task automatic test_bounds();
        do_reset();
        nPC = 64'd1014; imem_bytes = IRMOVQ;
        exp_q.push_back(mk(4'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd1024, 64'd1024, 1'b0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL bounds_edge got=%h exp=%h", obs, e); end
        nPC = 64'd1020;
`ifdef IMEM_BOUNDS_EN
        exp_q.push_back(mk(4'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1020, 64'd1020, 1'b1));
`else
        exp_q.push_back(mk(4'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd1030, 64'd1030, 1'b0));
`endif
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL bounds_over got=%h exp=%h", obs, e); end
`ifndef IMEM_BOUNDS_EN
        nPC = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_q.push_back(mk(4'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd2, 64'd2, 1'b0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL valp_wrap got=%h exp=%h", obs, e); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] v, vp, pc;
        logic        nr, nv, bub;
        logic [79:0] by;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            ic = 4'($urandom_range(1, 11));
            fn = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            v  = {$urandom, $urandom};
            pc = 64'($urandom_range(0, 1000));
            bub = ($urandom_range(0, 7) == 0);
            nr = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
            nv = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
            by = {$urandom, $urandom, 16'($urandom)};
            by[7:0] = {ic, fn};
            if (nr) begin
                by[15:8] = {ra, rb};
                if (nv) by[79:16] = v;
            end else if (nv) begin
                by[71:8] = v;
            end
            vp = pc + 64'd1 + (nr ? 64'd1 : 64'd0) + (nv ? 64'd8 : 64'd0);
            nPC = pc; imem_bytes = by; D_bubble = bub;
            if (bub)
                exp_q.push_back(mk(4'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0,
                                   (ic == 4'h7 || ic == 4'h8) ? v : vp, 1'b0));
            else
                exp_q.push_back(mk(4'd1, ic, fn, nr ? ra : 4'hF, nr ? rb : 4'hF, nv ? v : 64'd0, vp,
                                   (ic == 4'h7 || ic == 4'h8) ? v : vp, 1'b0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL b2b%0d got=%h exp=%h", i, obs, e); end
        end
        D_bubble = 1'b0;
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_jmp();
        test_stall();
        test_ins_halt();
        test_hlt_reset();
        test_bounds();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
